param_load_counter: RTL and testbench
=====================================

# param_load_counter

Parametrised, loadable up/down counter. Generalises the fixed 10-bit load counter with four additions: configurable width and terminal value, up/down direction, wrap or saturate mode, and terminal/zero/overflow status. It is a leaf block driven by local control logic and by VPI-fed stimulus benches, and all of its outputs are registered.

## Interface
- WIDTH, 10, counter width in bits.
- MAX_COUNT, 2**WIDTH-1, terminal value; the count range is 0..MAX_COUNT.
- RESET_VAL, 0, value of count_out after reset.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  load data_in on this edge; has priority over counting.
- data_in  input  WIDTH  load value.
- count_en  input  1  step the count by one on this edge.
- up_dn  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  boundary behaviour: 1 = saturate, 0 = wrap.
- ovf_clr  input  1  clears the sticky overflow flag (only with the macro).
- count_out  output  WIDTH  current count.
- tc  output  1  high while count_out == MAX_COUNT.
- zero  output  1  high while count_out == 0.
- ovf  output  1  overflow/underflow status.

## Operation
- Parameter legality: MAX_COUNT <= 2**WIDTH-1 and RESET_VAL <= MAX_COUNT. Any violation raises an elaboration error.
- Reset values: count_out = RESET_VAL, tc = (RESET_VAL == MAX_COUNT), zero = (RESET_VAL == 0), ovf = 0.
- Each edge selects one action in this priority order: load, count, hold.
- Load (load_en = 1): count_out <= min(data_in, MAX_COUNT). Values above MAX_COUNT clamp to MAX_COUNT. A load never creates a boundary event, even if count_en is also 1.
- Count up (count_en = 1, up_dn = 1):
  - count_out < MAX_COUNT: increment by one.
  - count_out == MAX_COUNT, wrap mode: go to 0 and raise a boundary event.
  - count_out == MAX_COUNT, saturate mode: hold MAX_COUNT and raise a boundary event.
- Count down (count_en = 1, up_dn = 0):
  - count_out > 0: decrement by one.
  - count_out == 0, wrap mode: go to MAX_COUNT and raise a boundary event.
  - count_out == 0, saturate mode: hold 0 and raise a boundary event.
- Hold: both load_en and count_en are 0. count_out is unchanged and no event is raised.
- tc and zero are registered from the next-state count, so they always match count_out in the same cycle.
- Arithmetic is unsigned, WIDTH bits. The wrap boundary is MAX_COUNT, not 2**WIDTH, so non-power-of-two moduli are supported.
- ovf behaviour depends on the macro (see Configuration).

## Timing
- Inputs are sampled on the rising edge of clk. Every output updates one cycle later; there are no combinational input-to-output paths.
- A change on up_dn or sat_mode affects the first edge at which it is sampled and nothing earlier.
- reset takes effect immediately and asynchronously, independent of clk, and forces all reset values. This includes a reset asserted mid-cycle during a count or load.
- First edge after reset deasserts: normal operation resumes on that edge, with no extra idle cycle.
- A boundary event occurring on the same edge as ovf_clr sets ovf; set wins over clear.
- MAX_COUNT = 0 is legal: tc and zero are both permanently 1, and every count step is a boundary event.

## Configuration
- Macro LDCNT_OVF_STICKY_EN.
- Defined:
  - ovf sets on the edge of a boundary event and holds until an edge with ovf_clr = 1 and no concurrent event.
  - Loads do not affect ovf.
- Undefined:
  - ovf is a one-cycle pulse, high in the cycle following each boundary event.
  - Back-to-back events keep ovf high continuously.
  - ovf_clr is ignored and may be left unconnected.

## Test plan
Parameters for all scenarios: WIDTH = 10, MAX_COUNT = 999.
- Async reset: assert reset mid-cycle while counting at 0x155 -> before the next edge, count_out = 0, zero = 1, tc = 0, ovf = 0.
- Wrap up: load 997, then count up with sat_mode = 0 for 3 edges -> count_out sequence 998, 999 (tc = 1), 0 (zero = 1), and ovf asserts after the wrap.
- Clamp: load data_in = 1023 -> count_out = 999, tc = 1, ovf unchanged.
- Saturate down: load 1, then count down with sat_mode = 1 for 3 edges -> 0, 0, 0 with zero = 1. ovf pulses on each of the last two cycles (macro undefined) or is set and held (macro defined).
- Priority: count_out = 5, then load_en = 1, count_en = 1, data_in = 100 on the same edge -> count_out = 100, no ovf.
- Sticky clear (macro defined):
  - Force an overflow, then ovf_clr = 1 alone -> ovf = 0 next cycle.
  - Overflow event and ovf_clr = 1 on the same edge -> ovf = 1.

Source files
------------

// File: rtl/param_load_counter.sv
// rtl/param_load_counter.sv - parametrised loadable up/down counter with wrap/saturate and tc/zero/ovf status
// Define LDCNT_OVF_STICKY_EN for a sticky ovf cleared by ovf_clr; otherwise ovf is a one-cycle pulse.
module param_load_counter #(
   parameter int              WIDTH     = 10,
   parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
   parameter longint unsigned RESET_VAL = 64'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             count_en,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count_out,
   output logic             tc,
   output logic             zero,
   output logic             ovf
);

   generate
      if (WIDTH < 1 || WIDTH > 63 ||
          MAX_COUNT > ((64'd1 << WIDTH) - 64'd1) ||
          RESET_VAL > MAX_COUNT) begin : g_param_err
         $error("param_load_counter: illegal WIDTH/MAX_COUNT/RESET_VAL combination");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] next_count;
   logic             boundary;

   always_comb begin
      next_count = count_out;
      boundary   = 1'b0;
      if (load_en) begin
         next_count = (data_in > MAX_V) ? MAX_V : data_in;
      end else if (count_en) begin
         if (up_dn) begin
            // >= rather than == so an out-of-range count can never run past the terminal value
            if (count_out >= MAX_V) begin
               boundary   = 1'b1;
               next_count = sat_mode ? MAX_V : '0;
            end else begin
               next_count = count_out + WIDTH'(1);
            end
         end else begin
            if (count_out == '0) begin
               boundary   = 1'b1;
               next_count = sat_mode ? '0 : MAX_V;
            end else begin
               next_count = count_out - WIDTH'(1);
            end
         end
      end
   end

   // Status flags are derived from next_count so they line up with count_out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_out <= RESET_V;
         tc        <= (RESET_V == MAX_V);
         zero      <= (RESET_V == '0);
         ovf       <= 1'b0;
      end else begin
         count_out <= next_count;
         tc        <= (next_count == MAX_V);
         zero      <= (next_count == '0);
`ifdef LDCNT_OVF_STICKY_EN
         if (boundary)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
`else
         ovf <= boundary;
`endif
      end
   end

`ifndef LDCNT_OVF_STICKY_EN
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
`endif

endmodule

// File: tb/tb_param_load_counter.sv
// tb/tb_param_load_counter.sv - vector table, async reset sequence and randomized model check for param_load_counter
module tb_param_load_counter;

   localparam int W    = 10;
   localparam int MAXC = 999;
`ifdef LDCNT_OVF_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         load_en, count_en, up_dn, sat_mode, ovf_clr;
   logic [W-1:0] data_in;
   logic [W-1:0] count_out;
   logic         tc, zero, ovf;

   param_load_counter #(.WIDTH(W), .MAX_COUNT(MAXC), .RESET_VAL(0)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .data_in(data_in),
      .count_en(count_en), .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
      .count_out(count_out), .tc(tc), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   typedef struct {
      bit ld; int d; bit ce; bit up; bit sat; bit clr;
      int e_cnt; bit e_tc; bit e_zero; bit e_ovf;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input bit ld, input int d, input bit ce, input bit up, input bit sat,
                      input bit clr, input int e_cnt, input bit e_tc, input bit e_zero, input bit e_ovf);
      vec_t v;
      v = '{ld, d, ce, up, sat, clr, e_cnt, e_tc, e_zero, e_ovf};
      vecs.push_back(v);
   endtask

   // Reference model: count as plain integers on the ring 0..MAXC.
   int m_count;
   bit m_ovf;

   task automatic model_step();
      int nxt;
      bit evt;
      nxt = m_count;
      evt = 1'b0;
      if (load_en) begin
         nxt = (int'(data_in) > MAXC) ? MAXC : int'(data_in);
      end else if (count_en && up_dn) begin
         evt = (m_count + 1 > MAXC);
         nxt = sat_mode ? ((m_count + 1 > MAXC) ? MAXC : m_count + 1) : (m_count + 1) % (MAXC + 1);
      end else if (count_en) begin
         evt = (m_count == 0);
         nxt = sat_mode ? ((m_count == 0) ? 0 : m_count - 1) : (m_count - 1 + MAXC + 1) % (MAXC + 1);
      end
      m_count = nxt;
      if (STICKY) m_ovf = evt ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      else        m_ovf = evt;
   endtask

   task automatic check_model(input string tag);
      check({tag, " count"}, int'(count_out), m_count);
      check({tag, " tc"},    int'(tc),        int'(m_count == MAXC));
      check({tag, " zero"},  int'(zero),      int'(m_count == 0));
      check({tag, " ovf"},   int'(ovf),       int'(m_ovf));
   endtask

   task automatic idle_inputs();
      load_en = 0; data_in = '0; count_en = 0; up_dn = 1; sat_mode = 0; ovf_clr = 0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("reset count", int'(count_out), 0);
      check("reset tc",    int'(tc),        0);
      check("reset zero",  int'(zero),      1);
      check("reset ovf",   int'(ovf),       0);
      reset = 1'b0;

      //   ld  d     ce up sat clr  cnt  tc zero ovf
      add(1, 997,  0, 1, 0, 0,   997, 0, 0, 0);
      add(0, 0,    1, 1, 0, 0,   998, 0, 0, 0);
      add(0, 0,    1, 1, 0, 0,   999, 1, 0, 0);
      add(0, 0,    1, 1, 0, 0,   0,   0, 1, 1);
      add(1, 1023, 1, 1, 0, 0,   999, 1, 0, STICKY);
      add(1, 1,    0, 0, 1, 0,   1,   0, 0, STICKY);
      add(0, 0,    1, 0, 1, 0,   0,   0, 1, STICKY);
      add(0, 0,    1, 0, 1, 0,   0,   0, 1, 1);
      add(0, 0,    1, 0, 1, 0,   0,   0, 1, 1);
      add(1, 5,    0, 1, 0, 0,   5,   0, 0, STICKY);
      add(1, 100,  1, 1, 0, 0,   100, 0, 0, STICKY);
      add(0, 0,    0, 0, 1, 0,   100, 0, 0, STICKY);
      add(0, 0,    0, 1, 0, 1,   100, 0, 0, 0);
      add(1, 999,  0, 1, 0, 0,   999, 1, 0, 0);
      add(0, 0,    1, 1, 0, 1,   0,   0, 1, 1);
      add(0, 0,    0, 1, 0, 0,   0,   0, 1, STICKY);
      add(0, 0,    0, 1, 0, 1,   0,   0, 1, 0);
      add(1, 999,  0, 1, 1, 0,   999, 1, 0, 0);
      add(0, 0,    1, 1, 1, 0,   999, 1, 0, 1);
      add(1, 0,    0, 0, 0, 0,   0,   0, 1, STICKY);
      add(0, 0,    1, 0, 0, 0,   999, 1, 0, 1);
      add(0, 0,    1, 0, 0, 0,   998, 0, 0, STICKY);

      foreach (vecs[i]) begin
         load_en = vecs[i].ld; data_in = W'(vecs[i].d); count_en = vecs[i].ce;
         up_dn = vecs[i].up; sat_mode = vecs[i].sat; ovf_clr = vecs[i].clr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d count", i), int'(count_out), vecs[i].e_cnt);
         check($sformatf("vec%0d tc", i),    int'(tc),        int'(vecs[i].e_tc));
         check($sformatf("vec%0d zero", i),  int'(zero),      int'(vecs[i].e_zero));
         check($sformatf("vec%0d ovf", i),   int'(ovf),       int'(vecs[i].e_ovf));
      end

      // Asynchronous reset landing mid-cycle while counting from 0x155.
      idle_inputs();
      load_en = 1; data_in = 10'h155;
      @(posedge clk);
      #1;
      load_en = 0; count_en = 1; up_dn = 1;
      @(posedge clk);
      #1;
      check("pre-reset count", int'(count_out), 'h156);
      #2;
      reset = 1'b1;
      #1;
      check("async reset count", int'(count_out), 0);
      check("async reset zero",  int'(zero),      1);
      check("async reset tc",    int'(tc),        0);
      check("async reset ovf",   int'(ovf),       0);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("first edge after reset", int'(count_out), 1);

      m_count = 1;
      m_ovf   = 1'b0;
      for (int c = 0; c < 600; c++) begin
         load_en  = ($urandom_range(0, 99) < 8);
         case ($urandom_range(0, 3))
            0:       data_in = W'($urandom_range(1000, 1023));
            1:       data_in = W'($urandom_range(0, 2));
            2:       data_in = W'($urandom_range(996, 999));
            default: data_in = W'($urandom_range(0, 1023));
         endcase
         count_en = ($urandom_range(0, 3) != 0);
         up_dn    = $urandom_range(0, 1);
         sat_mode = $urandom_range(0, 1);
         ovf_clr  = ($urandom_range(0, 3) == 0);
         model_step();
         @(posedge clk);
         #1;
         check_model($sformatf("rand%0d", c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
